adam_apb_arbiter: RTL and testbench
===================================

ADAM_APB_ARBITER -- requirements
Module: adam_apb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter NO_MSTS, default 4, number of APB requesters; legal range 2..16.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 pause_req  in  1  request to quiesce; pause_ack  out  1  quiesced acknowledge.
REQ-007 m_psel, m_penable, m_pwrite  in  NO_MSTS  per-requester APB controls.
REQ-008 m_paddr  in  NO_MSTS*ADDR_WIDTH; m_pwdata  in  NO_MSTS*DATA_WIDTH; m_pstrb  in  NO_MSTS*STRB_WIDTH; m_pprot  in  NO_MSTS*3.
REQ-009 m_pready, m_pslverr  out  NO_MSTS; m_prdata  out  NO_MSTS*DATA_WIDTH  per-requester responses.
REQ-010 s_psel, s_penable, s_pwrite  out  1; s_paddr  out  ADDR_WIDTH; s_pwdata  out  DATA_WIDTH; s_pstrb  out  STRB_WIDTH; s_pprot  out  3  shared completer request.
REQ-011 s_pready, s_pslverr  in  1; s_prdata  in  DATA_WIDTH  shared completer response.

Function
REQ-012 FSM states: IDLE, SETUP, ACCESS, PAUSED; one transfer in flight at most.
REQ-013 IDLE: pause_req=1 -> PAUSED (priority over requests); else any m_psel=1 -> latch grant index g, SETUP; else stay.
REQ-014 Grant: round-robin, search starts at last_grant+1 modulo NO_MSTS; last_grant updated when grant latched.
REQ-015 Request fields (paddr, pwrite, pwdata, pstrb, pprot) of requester g are registered at grant and held constant until transfer ends.
REQ-016 SETUP: s_psel=1, s_penable=0; unconditionally -> ACCESS next cycle.
REQ-017 ACCESS: s_psel=1, s_penable=1; stay while s_pready=0 (unbounded wait states).
REQ-018 ACCESS with s_pready=1: same cycle m_pready[g]=1, m_prdata[g]=s_prdata, m_pslverr[g]=s_pslverr (combinational pass-through); next state PAUSED if pause_req=1, else IDLE.
REQ-019 Minimum transfer latency: grant edge to m_pready[g] = 2 cycles; one IDLE cycle between consecutive transfers.
REQ-020 Non-granted requesters and all requesters outside the completing cycle: m_pready=0, m_prdata=0, m_pslverr=0.
REQ-021 s_* request outputs driven 0 in IDLE and PAUSED.
REQ-022 Requester deasserting m_psel after grant: transfer still completes on completer side; m_pready[g] still pulsed.
REQ-023 Simultaneous requests: exactly one granted per arbitration; a continuously requesting master is served within NO_MSTS transfers.
REQ-024 PAUSED: pause_ack=1, no grants; pause_req=0 -> IDLE, pause_ack=0 in IDLE.
REQ-025 pause_req raised during SETUP/ACCESS: in-flight transfer completes, then PAUSED; pause_ack never asserted with s_psel=1.

Reset
REQ-026 rst_n=0 asynchronously forces: state IDLE, last_grant=NO_MSTS-1 (master 0 wins first), registered request fields 0, all outputs 0 including pause_ack.
REQ-027 Reset mid-transfer: s_psel drops immediately; transfer abandoned, no m_pready pulse.

Structure
REQ-028 State enum and grant-index width ($clog2(NO_MSTS)) in shared package adam_apb_arbiter_pkg.
REQ-029 Round-robin selection in sub-module adam_rr_arbiter (combinational: req vector, last_grant -> valid, index).

Verification (NO_MSTS=4, 32-bit)
REQ-030 Single write m1 addr 0x0001_0000 data 0xDEADBEEF strb 4'hF, s_pready=1 -> s_psel two cycles, s_penable second, m_pready[1] 2 cycles after grant, s_pwdata=0xDEADBEEF.
REQ-031 All four request reads at reset release, completer returns index as data -> grant order 0,1,2,3; m_prdata[i]=i; one IDLE cycle between.
REQ-032 m2 read, completer holds s_pready=0 five cycles then 1 with s_pslverr=1, s_prdata=0x55 -> ACCESS held 6 cycles; m_pslverr[2]=1, m_prdata[2]=0x55 single cycle.
REQ-033 pause_req raised in SETUP of m0 transfer -> transfer completes, pause_ack=1 next cycle, pending m3 not granted until pause_req=0, then granted.
REQ-034 m0 and m1 continuously requesting, m1 last served -> grants alternate 0,1,0,1.
REQ-035 rst_n=0 during ACCESS -> all outputs 0 same cycle; after release first grant goes to lowest requesting index.

Source files
------------

// File: rtl/adam_apb_arbiter_pkg.sv
// Shared definitions for the APB requester arbiter: FSM state encoding and
// grant-index width helper.
package adam_apb_arbiter_pkg;

  // FSM state encoding. At most one transfer is in flight at any time.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  localparam int MIN_MSTS = 2;
  localparam int MAX_MSTS = 16;

  // Width of a grant index for n requesters. The result is never below 1.
  function automatic int gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adam_rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the last
// winner and wraps modulo N. The first asserted request found wins.
module adam_rr_arbiter
  import adam_apb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = gnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Rotating priority scan: last+1 has the highest priority, last the lowest.
  always_comb begin
    int c;
    c   = 0;
    vld = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!vld && req[c]) begin
        vld = 1'b1;
        idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/adam_apb_arbiter.sv
// N-to-1 APB arbiter. Requesters share one completer under round-robin
// grant. The selected request is captured at grant and replayed as a
// SETUP/ACCESS pair. The completer response is steered back combinationally
// to the granted requester. pause_req quiesces the bus between transfers.
module adam_apb_arbiter
  import adam_apb_arbiter_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NO_MSTS    = 4,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic                             pause_req,
  output logic                             pause_ack,

  input  logic [NO_MSTS-1:0]               m_psel,
  input  logic [NO_MSTS-1:0]               m_penable,
  input  logic [NO_MSTS-1:0]               m_pwrite,
  input  logic [NO_MSTS*ADDR_WIDTH-1:0]    m_paddr,
  input  logic [NO_MSTS*DATA_WIDTH-1:0]    m_pwdata,
  input  logic [NO_MSTS*STRB_WIDTH-1:0]    m_pstrb,
  input  logic [NO_MSTS*3-1:0]             m_pprot,
  output logic [NO_MSTS-1:0]               m_pready,
  output logic [NO_MSTS-1:0]               m_pslverr,
  output logic [NO_MSTS*DATA_WIDTH-1:0]    m_prdata,

  output logic                             s_psel,
  output logic                             s_penable,
  output logic                             s_pwrite,
  output logic [ADDR_WIDTH-1:0]            s_paddr,
  output logic [DATA_WIDTH-1:0]            s_pwdata,
  output logic [STRB_WIDTH-1:0]            s_pstrb,
  output logic [2:0]                       s_pprot,
  input  logic                             s_pready,
  input  logic                             s_pslverr,
  input  logic [DATA_WIDTH-1:0]            s_prdata
);

  localparam int IW = gnt_w(NO_MSTS);

  // Request fields of one requester. These fields are captured at grant.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
    logic [2:0]            prot;
  } req_t;

  logic [1:0]           state;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        gnt;
  req_t                 r_req;
  req_t [NO_MSTS-1:0]   m_req;

  logic                 arb_vld;
  logic [IW-1:0]        arb_idx;
  logic                 busy;
  logic                 done;

  // Requesters drive m_penable for their own protocol. Arbitration only uses m_psel.
  logic                 unused_penable;
  assign unused_penable = ^m_penable;

  adam_rr_arbiter #(.N(NO_MSTS), .IW(IW)) u_rr (
    .req  (m_psel),
    .last (last_grant),
    .vld  (arb_vld),
    .idx  (arb_idx)
  );

  assign busy = (state == ST_SETUP) || (state == ST_ACCESS);
  assign done = (state == ST_ACCESS) && s_pready;

  // Per-requester lanes: unpack the flat request buses and steer the response.
  // Only the granted lane sees the response, and only in its completing cycle.
  for (genvar i = 0; i < NO_MSTS; i++) begin : g_lane
    logic hit;
    assign m_req[i] = '{
      addr:  m_paddr [i*ADDR_WIDTH +: ADDR_WIDTH],
      write: m_pwrite[i],
      wdata: m_pwdata[i*DATA_WIDTH +: DATA_WIDTH],
      strb:  m_pstrb [i*STRB_WIDTH +: STRB_WIDTH],
      prot:  m_pprot [i*3 +: 3]
    };
    assign hit                               = done && (gnt == IW'(i));
    assign m_pready[i]                       = hit;
    assign m_pslverr[i]                      = hit & s_pslverr;
    assign m_prdata[i*DATA_WIDTH +: DATA_WIDTH] = hit ? s_prdata : '0;
  end

  // Transfer sequencing. A request is granted and captured from IDLE.
  // A pending pause request wins over a new grant and is honoured after a transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NO_MSTS - 1);
      gnt        <= '0;
      r_req      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pause_req) begin
            state <= ST_PAUSED;
          end else if (arb_vld) begin
            state      <= ST_SETUP;
            gnt        <= arb_idx;
            last_grant <= arb_idx;
            r_req      <= m_req[arb_idx];
          end
        end
        ST_SETUP:  state <= ST_ACCESS;
        ST_ACCESS: begin
          if (s_pready) state <= pause_req ? ST_PAUSED : ST_IDLE;
        end
        ST_PAUSED: begin
          if (!pause_req) state <= ST_IDLE;
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Completer-side request. These outputs are forced to zero when no transfer is in flight.
  always_comb begin
    s_psel    = busy;
    s_penable = (state == ST_ACCESS);
    s_pwrite  = busy & r_req.write;
    s_paddr   = busy ? r_req.addr  : '0;
    s_pwdata  = busy ? r_req.wdata : '0;
    s_pstrb   = busy ? r_req.strb  : '0;
    s_pprot   = busy ? r_req.prot  : '0;
    pause_ack = (state == ST_PAUSED);
  end

endmodule

// File: tb/tb_adam_apb_arbiter.sv
// Directed bench for adam_apb_arbiter (4 requesters, 32-bit). Stimulus pushes
// the expected completions into a scoreboard queue. A monitor pops and
// compares on every m_pready pulse.
module tb_adam_apb_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pause_req;
  logic              pause_ack;
  logic [3:0]        m_psel, m_penable, m_pwrite;
  logic [3:0][31:0]  m_paddr, m_pwdata;
  logic [3:0][3:0]   m_pstrb;
  logic [3:0][2:0]   m_pprot;
  logic [3:0]        m_pready, m_pslverr;
  logic [3:0][31:0]  m_prdata;
  logic              s_psel, s_penable, s_pwrite;
  logic [31:0]       s_paddr, s_pwdata, s_prdata;
  logic [3:0]        s_pstrb;
  logic [2:0]        s_pprot;
  logic              s_pready, s_pslverr;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Completer model: cfg_ws wait states; data fixed or address>>4
  int          cfg_ws    = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  bit          cfg_mode  = 1'b0;
  int          wcnt      = 0;
  logic        in_acc;

  assign in_acc    = s_psel & s_penable;
  assign s_pready  = in_acc && (wcnt == cfg_ws);
  assign s_prdata  = s_pready ? (cfg_mode ? (s_paddr >> 4) : cfg_rdata) : 32'h0;
  assign s_pslverr = s_pready & cfg_err;
  assign m_penable = m_psel;

  always @(posedge clk) begin
    if (in_acc && !s_pready) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  always #5 clk = ~clk;

  adam_apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_MSTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e;
    q.push_back(x);
  endtask

  task automatic setm(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    m_paddr[i]  = a;
    m_pwdata[i] = d;
    m_pwrite[i] = wr;
    m_pstrb[i]  = 4'hF;
    m_pprot[i]  = 3'(i);
    m_psel[i]   = 1'b1;
  endtask

  // Wait for n completions. Optionally drop each served request and check the completion spacing.
  task automatic serve_n(input int n, input bit drop, input int gap);
    logic [3:0] seen;
    seen = '0;
    for (int k = 0; k < n; k++) begin
      int cyc;
      bit got;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (|m_pready) begin got = 1'b1; seen = m_pready; end
      end
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL serve_timeout: got no m_pready expected completion %0d", k);
      end else if (gap != 0 && k > 0) begin
        check("xfer_gap", 64'(cyc), 64'(gap));
      end
      @(posedge clk); #1;
      if (drop && got) m_psel = m_psel & ~seen;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [3:0][31:0] ed;
    logic [3:0]       ev, ee;
    exp_t             e;
    if (rst_n && pause_ack && s_psel) begin
      n_fail++;
      $display("FAIL ack_with_psel: got pause_ack=1 s_psel=1 expected not both");
    end
    if (!(|m_pready) && (m_prdata != '0 || m_pslverr != '0)) begin
      n_fail++;
      $display("FAIL idle_resp: got prdata=%0h pslverr=%0h expected 0", m_prdata, m_pslverr);
    end
    if (|m_pready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got m_pready=%b expected none", m_pready);
      end else begin
        e  = q.pop_front();
        ed = '0; ev = '0; ee = '0;
        ed[e.idx] = e.data;
        ev[e.idx] = 1'b1;
        ee[e.idx] = e.err;
        if (m_pready !== ev || m_prdata !== ed || m_pslverr !== ee) begin
          n_fail++;
          $display("FAIL sb_resp: got pready=%b prdata=%h err=%b expected pready=%b prdata=%h err=%b",
                   m_pready, m_prdata, m_pslverr, ev, ed, ee);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; pause_req = 1'b0;
    m_psel = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
    #1;
    check("rst_psel",   64'(s_psel),    64'd0);
    check("rst_ack",    64'(pause_ack), 64'd0);
    check("rst_pready", 64'(m_pready),  64'd0);
    check("rst_paddr",  64'(s_paddr),   64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single write from m1
    @(posedge clk); #1;
    setm(1, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF);
    push(1, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("w_setup_sel",  64'({s_psel, s_penable}), 64'b10);
    check("w_paddr",      64'(s_paddr),  64'h0001_0000);
    check("w_pwdata",     64'(s_pwdata), 64'hDEAD_BEEF);
    check("w_pwrite_strb", 64'({s_pwrite, s_pstrb, s_pprot}), 64'({1'b1, 4'hF, 3'd1}));
    @(negedge clk);
    check("w_access_sel", 64'({s_psel, s_penable}), 64'b11);
    check("w_pready_lat", 64'(m_pready), 64'b0010);
    @(posedge clk); #1;
    m_psel[1] = 1'b0;
    @(negedge clk);
    check("w_idle_sel",   64'({s_psel, s_penable, s_paddr}), 64'd0);

    // All four request at reset release; completer returns the index
    @(negedge clk) rst_n = 1'b0;
    cfg_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setm(i, 1'b0, 32'(i) << 4, 32'h0);
      push(i, 32'(i), 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    serve_n(4, 1'b1, 3);
    cfg_mode = 1'b0;

    // m2 read with five wait states and an error response
    cfg_ws = 5; cfg_err = 1'b1; cfg_rdata = 32'h55;
    setm(2, 1'b0, 32'h200, 32'h0);
    push(2, 32'h55, 1'b1);
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_penable) cnt++;
      if (m_pready[2]) break;
    end
    check("ws_access_cycles", 64'(cnt), 64'd6);
    @(posedge clk); #1;
    m_psel[2] = 1'b0;
    @(negedge clk);
    check("ws_single_pulse", 64'({m_pready, m_pslverr}), 64'd0);
    cfg_ws = 0; cfg_err = 1'b0; cfg_rdata = 32'hA0;

    // Pause raised during SETUP of an m0 transfer while m3 is pending
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    setm(0, 1'b0, 32'h300, 32'h0);
    setm(3, 1'b0, 32'h3300, 32'h0);
    push(0, 32'hA0, 1'b0);
    @(posedge clk); #1;
    pause_req = 1'b1;
    @(negedge clk);
    check("p_setup_m0", 64'({s_psel, s_penable, s_paddr}), 64'({2'b10, 32'h300}));
    @(negedge clk);
    @(posedge clk); #1;
    m_psel[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("p_held", 64'({pause_ack, s_psel}), 64'b10);
    end
    @(posedge clk); #1;
    pause_req = 1'b0;
    push(3, 32'hA0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("p_idle_ack", 64'({pause_ack, s_psel}), 64'b00);
    @(posedge clk);
    @(negedge clk);
    check("p_grant_m3", 64'({s_psel, s_paddr}), 64'({1'b1, 32'h3300}));
    serve_n(1, 1'b1, 0);

    // m1 served, then m0 and m1 continuously requesting
    setm(1, 1'b0, 32'h1100, 32'h0);
    push(1, 32'hA0, 1'b0);
    serve_n(1, 1'b1, 0);
    setm(0, 1'b0, 32'h300, 32'h0);
    setm(1, 1'b0, 32'h1100, 32'h0);
    push(0, 32'hA0, 1'b0); push(1, 32'hA0, 1'b0);
    push(0, 32'hA0, 1'b0); push(1, 32'hA0, 1'b0);
    serve_n(4, 1'b0, 3);
    m_psel = '0;

    // Reset during ACCESS of an m3 transfer; m1 wins after release
    cfg_ws = 3;
    setm(1, 1'b0, 32'h1100, 32'h0);
    setm(3, 1'b0, 32'h3300, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("r_grant_m3", 64'(s_paddr), 64'h3300);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("r_async_s", 64'({s_psel, s_penable, s_paddr}), 64'd0);
    check("r_async_m", 64'({m_pready, pause_ack}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; cfg_ws = 0;
    push(1, 32'hA0, 1'b0); push(3, 32'hA0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("r_first_grant", 64'(s_paddr), 64'h1100);
    serve_n(2, 1'b1, 0);

    @(negedge clk);
    check("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
